morse_char_encoder: RTL and testbench



---
 rtl/morse_char_encoder.sv | 176 +++++++++++++++++
 tb/tb_morse_char_encoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_encoder.sv
// Morse character encoder: takes one ASCII character per valid/ready handshake and
// emits spaced single-cycle dot/dash/char-space/word-space pulses for a transmit FSM.
module morse_char_encoder #(
  parameter int ELEM_GAP = 2,
  parameter int CHAR_GAP = 4,
  parameter int WORD_GAP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       dot_out,
  output logic       dash_out,
  output logic       char_space_out,
  output logic       word_space_out,
  output logic       err_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ELEM  = 3'd1;
  localparam logic [2:0] S_EGAP  = 3'd2;
  localparam logic [2:0] S_END   = 3'd3;
  localparam logic [2:0] S_SPACE = 3'd4;
  localparam logic [2:0] S_TAIL  = 3'd5;

  logic [2:0] state;
  logic [3:0] cnt;
  logic [4:0] pat;
  logic [2:0] rem;

  logic [7:0] lookup;
  logic [2:0] len;
  logic [4:0] aligned;
  logic [3:0] gap_sel;

  // Code ROM entry {length, pattern}; pattern bits right-aligned, MSB-first, 1=dash.
  // Length 0 marks an unsupported character.
  function automatic logic [7:0] code_rom(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7a) ? (c - 8'h20) : c;
    case (u)
      8'h41: code_rom = {3'd2, 5'b00001}; // A .-
      8'h42: code_rom = {3'd4, 5'b01000}; // B -...
      8'h43: code_rom = {3'd4, 5'b01010}; // C -.-.
      8'h44: code_rom = {3'd3, 5'b00100}; // D -..
      8'h45: code_rom = {3'd1, 5'b00000}; // E .
      8'h46: code_rom = {3'd4, 5'b00010}; // F ..-.
      8'h47: code_rom = {3'd3, 5'b00110}; // G --.
      8'h48: code_rom = {3'd4, 5'b00000}; // H ....
      8'h49: code_rom = {3'd2, 5'b00000}; // I ..
      8'h4a: code_rom = {3'd4, 5'b00111}; // J .---
      8'h4b: code_rom = {3'd3, 5'b00101}; // K -.-
      8'h4c: code_rom = {3'd4, 5'b00100}; // L .-..
      8'h4d: code_rom = {3'd2, 5'b00011}; // M --
      8'h4e: code_rom = {3'd2, 5'b00010}; // N -.
      8'h4f: code_rom = {3'd3, 5'b00111}; // O ---
      8'h50: code_rom = {3'd4, 5'b00110}; // P .--.
      8'h51: code_rom = {3'd4, 5'b01101}; // Q --.-
      8'h52: code_rom = {3'd3, 5'b00010}; // R .-.
      8'h53: code_rom = {3'd3, 5'b00000}; // S ...
      8'h54: code_rom = {3'd1, 5'b00001}; // T -
      8'h55: code_rom = {3'd3, 5'b00001}; // U ..-
      8'h56: code_rom = {3'd4, 5'b00001}; // V ...-
      8'h57: code_rom = {3'd3, 5'b00011}; // W .--
      8'h58: code_rom = {3'd4, 5'b01001}; // X -..-
      8'h59: code_rom = {3'd4, 5'b01011}; // Y -.--
      8'h5a: code_rom = {3'd4, 5'b01100}; // Z --..
      8'h30: code_rom = {3'd5, 5'b11111}; // 0 -----
      8'h31: code_rom = {3'd5, 5'b01111}; // 1 .----
      8'h32: code_rom = {3'd5, 5'b00111}; // 2 ..---
      8'h33: code_rom = {3'd5, 5'b00011}; // 3 ...--
      8'h34: code_rom = {3'd5, 5'b00001}; // 4 ....-
      8'h35: code_rom = {3'd5, 5'b00000}; // 5 .....
      8'h36: code_rom = {3'd5, 5'b10000}; // 6 -....
      8'h37: code_rom = {3'd5, 5'b11000}; // 7 --...
      8'h38: code_rom = {3'd5, 5'b11100}; // 8 ---..
      8'h39: code_rom = {3'd5, 5'b11110}; // 9 ----.
      default: code_rom = 8'h00;
    endcase
  endfunction

  always_comb begin
    lookup  = code_rom(char_in);
    len     = lookup[7:5];
    // Left-justify so the first element always sits in bit 4.
    aligned = lookup[4:0] << (3'd5 - len);
    gap_sel = (state == S_END) ? 4'(CHAR_GAP) : 4'(WORD_GAP);
  end

  // Handshake: a character is taken at a rising edge with char_valid && char_ready;
  // char_ready is only high in IDLE and inputs are ignored otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      pat            <= 5'd0;
      rem            <= 3'd0;
      char_ready     <= 1'b1;
      dot_out        <= 1'b0;
      dash_out       <= 1'b0;
      char_space_out <= 1'b0;
      word_space_out <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      dot_out        <= 1'b0;
      dash_out       <= 1'b0;
      char_space_out <= 1'b0;
      word_space_out <= 1'b0;
      err_out        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (char_valid) begin
            if (char_in == 8'h20) begin
              word_space_out <= 1'b1;
              char_ready     <= 1'b0;
              state          <= S_SPACE;
            end else if (len != 3'd0) begin
              dash_out   <= aligned[4];
              dot_out    <= ~aligned[4];
              pat        <= {aligned[3:0], 1'b0};
              rem        <= len - 3'd1;
              char_ready <= 1'b0;
              state      <= S_ELEM;
            end else begin
              err_out <= 1'b1;
            end
          end
        end
        S_ELEM: begin
          cnt   <= 4'(ELEM_GAP - 1);
          state <= S_EGAP;
        end
        S_EGAP: begin
          if (cnt == 4'd1) begin
            if (rem != 3'd0) begin
              dash_out <= pat[4];
              dot_out  <= ~pat[4];
              pat      <= {pat[3:0], 1'b0};
              rem      <= rem - 3'd1;
              state    <= S_ELEM;
            end else begin
              char_space_out <= 1'b1;
              state          <= S_END;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_END, S_SPACE: begin
          // The terminating pulse cycle counts toward the gap; ready rises at t+GAP-1.
          if (gap_sel == 4'd2) begin
            char_ready <= 1'b1;
            state      <= S_IDLE;
          end else begin
            cnt   <= gap_sel - 4'd2;
            state <= S_TAIL;
          end
        end
        S_TAIL: begin
          if (cnt == 4'd1) begin
            char_ready <= 1'b1;
            state      <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          char_ready <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_char_encoder.sv
// Bench for morse_char_encoder: directed test-plan characters, reset mid-character,
// then random characters, checked cycle by cycle against a string-table Morse model.
module tb_morse_char_encoder;

  localparam int ELEM_GAP = 2;
  localparam int CHAR_GAP = 4;
  localparam int WORD_GAP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       dot_out;
  logic       dash_out;
  logic       char_space_out;
  logic       word_space_out;
  logic       err_out;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle vector {ready, dot, dash, char_space, word_space, err}.
  logic [5:0] exp_q[$];

  string let_tab[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                         ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                         "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string dig_tab[10] = '{"-----", ".----", "..---", "...--", "....-",
                         ".....", "-....", "--...", "---..", "----."};

  morse_char_encoder #(
    .ELEM_GAP(ELEM_GAP),
    .CHAR_GAP(CHAR_GAP),
    .WORD_GAP(WORD_GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .char_in(char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .dot_out(dot_out),
    .dash_out(dash_out),
    .char_space_out(char_space_out),
    .word_space_out(word_space_out),
    .err_out(err_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic string morse(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7a) return let_tab[int'(c - 8'h61)];
    if (c >= 8'h41 && c <= 8'h5a) return let_tab[int'(c - 8'h41)];
    if (c >= 8'h30 && c <= 8'h39) return dig_tab[int'(c - 8'h30)];
    return "";
  endfunction

  function automatic logic [5:0] obs_vec();
    return {char_ready, dot_out, dash_out, char_space_out, word_space_out, err_out};
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (rdy,dot,dash,cs,ws,err)", tag, obs, exp);
    end
  endtask

  // Build the expected trace of one character from its Morse string and the gap rules.
  task automatic build_expect(input logic [7:0] c);
    string s;
    int n, t, last;
    logic [5:0] v;
    s = morse(c);
    n = s.len();
    if (c == 8'h20) begin
      t = 1;
      last = WORD_GAP;
    end else if (n > 0) begin
      t = 1 + n * ELEM_GAP;
      last = t + CHAR_GAP - 1;
    end else begin
      t = 0;
      last = 1;
    end
    for (int j = 1; j <= last; j++) begin
      v = 6'b0;
      v[5] = (j >= last);
      if (c == 8'h20) begin
        v[1] = (j == 1);
      end else if (n > 0) begin
        if (j < t && ((j - 1) % ELEM_GAP) == 0) begin
          if (s[(j - 1) / ELEM_GAP] == 8'h2E) v[4] = 1'b1;
          else v[3] = 1'b1;
        end
        v[2] = (j == t);
      end else begin
        v[0] = (j == 1);
      end
      exp_q.push_back(v);
    end
  endtask

  // Present a character, get it accepted, then score every cycle until ready returns.
  // Junk is driven on char_in/char_valid while busy to show inputs are ignored.
  task automatic send(input logic [7:0] c, input string tag);
    int cyc;
    logic [5:0] e;
    cyc = 0;
    while (char_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    assert (char_ready === 1'b1) else begin
      errors++;
      $error("FAIL %s_ready_wait observed=%b expected=1", tag, char_ready);
    end
    char_in = c;
    char_valid = 1'b1;
    build_expect(c);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk(tag, obs_vec(), e);
      if (exp_q.size() > 0) begin
        char_valid = 1'($urandom_range(0, 1));
        char_in = 8'($urandom);
      end else begin
        char_valid = 1'b0;
      end
    end
  endtask

  function automatic logic [7:0] rand_char();
    case ($urandom_range(0, 5))
      0: return 8'($urandom_range(8'h41, 8'h5a));
      1: return 8'($urandom_range(8'h61, 8'h7a));
      2: return 8'($urandom_range(8'h30, 8'h39));
      3: return 8'h20;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    char_valid = 1'b0;
    char_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_state", obs_vec(), 6'b100000);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", obs_vec(), 6'b100000);

    send(8'h45, "E");
    send(8'h61, "a");
    send(8'h54, "T_back_to_back");
    send(8'h30, "zero");
    send(8'h20, "space1");
    send(8'h20, "space2");
    send(8'h23, "hash_err");
    send(8'h42, "B_after_err");
    send(8'h7a, "z_lower");
    send(8'h20, "space_after_letter");
    send(8'h39, "nine");

    // Reset in the middle of '0': accept at k, rst for edge k+4.
    char_in = 8'h30;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    chk("rst_mid_k1", obs_vec(), 6'b001000);
    @(negedge clk);
    chk("rst_mid_k2", obs_vec(), 6'b000000);
    @(negedge clk);
    chk("rst_mid_k3", obs_vec(), 6'b001000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_k5", obs_vec(), 6'b100000);
    send(8'h45, "E_after_rst");

    for (int i = 0; i < 40; i++) begin
      send(rand_char(), "random");
    end

    repeat (3) @(negedge clk);
    chk("final_idle", obs_vec(), 6'b100000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
